// File: rtl/dispatcher_pkg.sv
// Shared types and helpers for the lane dispatcher: FSM encoding, width
// derivation, popcount and lane-word pack/unpack.
package dispatcher_pkg;

  localparam int unsigned MAX_LANES = 64;
  localparam int unsigned MAX_BW    = 64;
  localparam int unsigned MAX_LW    = MAX_BW + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  function automatic int unsigned n_lanes(input int unsigned log_n);
    return 32'd1 << log_n;
  endfunction

  function automatic int unsigned lane_bits(input int unsigned log_bw, input int unsigned ctrl);
    return (32'd1 << log_bw) + ctrl;
  endfunction

  function automatic int unsigned popcount(input logic [MAX_LANES-1:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < MAX_LANES; i++) begin
      c += 32'(v[i]);
    end
    return c;
  endfunction

  // Lane word layout: valid flag directly above the bw-bit payload.
  function automatic logic [MAX_LW-1:0] lane_pack(input logic vld, input logic [MAX_BW-1:0] d,
                                                  input int unsigned bw);
    logic [MAX_LW-1:0] w;
    w     = {1'b0, d};
    w[bw] = vld;
    return w;
  endfunction

  function automatic void lane_unpack(input logic [MAX_LW-1:0] w, input int unsigned bw,
                                      output logic vld, output logic [MAX_BW-1:0] d);
    vld = w[bw];
    d   = w[MAX_BW-1:0] & ((MAX_BW'(1) << bw) - MAX_BW'(1));
  endfunction

endpackage

// File: rtl/lane_dispatcher_compactor.sv
// Combinational lane compaction: packs consecutive ROM words onto non-stalled
// lanes by prefix rank and inserts feedback operands on feedback lanes.
module lane_compactor
  import dispatcher_pkg::*;
#(
  parameter int unsigned N  = 32,
  parameter int unsigned BW = 32,
  parameter int unsigned LW = 33,
  parameter int unsigned NW = 6
) (
  input  logic [N-1:0]    eff_stall_i,
  input  logic [N-1:0]    fb_sel_i,
  input  logic [NW-1:0]   n_iss_i,
  input  logic [N*LW-1:0] rom_data_i,
  input  logic [N*LW-1:0] rom_wgt_i,
  input  logic [N*BW-1:0] fb_data_i,
  output logic [N*LW-1:0] data_o,
  output logic [N*LW-1:0] wgt_o
);

  always_comb begin : rank_lanes
    int unsigned rank;
    data_o = '0;
    wgt_o  = '0;
    rank   = 0;
    for (int i = 0; i < N; i++) begin
      if (!eff_stall_i[i]) begin
        if (rank < 32'(n_iss_i)) begin
          data_o[i*LW +: LW] = rom_data_i[rank*LW +: LW];
          wgt_o[i*LW +: LW]  = rom_wgt_i[rank*LW +: LW];
        end
        rank = rank + 1;
      end else if (fb_sel_i[i]) begin
        data_o[i*LW +: LW] = LW'(lane_pack(1'b1, MAX_BW'(fb_data_i[i*BW +: BW]), BW));
      end
    end
  end

endmodule

// File: rtl/lane_dispatcher.sv
// Conv-layer operand dispatcher: streams compacted ROM operands to N lanes with
// backpressure and a one-entry skid buffer. DISPATCHER_PERF_CNT_EN adds a stall counter.
module lane_dispatcher
  import dispatcher_pkg::*;
#(
  parameter  int unsigned LOG_N_LANES   = 5,
  parameter  int unsigned LOG_BIT_WIDTH = 5,
  parameter  int unsigned CTRL_BIT      = 1,
  parameter  int unsigned LOG_ROM_SIZE  = 16,
  parameter  int unsigned OPS_W         = 32,
  localparam int unsigned N             = n_lanes(LOG_N_LANES),
  localparam int unsigned BW            = 32'd1 << LOG_BIT_WIDTH,
  localparam int unsigned LW            = lane_bits(LOG_BIT_WIDTH, CTRL_BIT),
  localparam int unsigned AW            = LOG_ROM_SIZE
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [OPS_W-1:0] init_n_ops,
  input  logic [AW-1:0]   init_data_base,
  input  logic [AW-1:0]   init_wgt_base,
  input  logic [AW-1:0]   wgt_period,
  input  logic [N-1:0]    stall_word,
  input  logic [N-1:0]    feedback_sel,
  input  logic [N*BW-1:0] feedback_data,
  output logic            rom_rd,
  output logic [AW-1:0]   rom_data_addr,
  output logic [AW-1:0]   rom_wgt_addr,
  input  logic [N*LW-1:0] rom_data_in,
  input  logic [N*LW-1:0] rom_wgt_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N*LW-1:0] mult_in_data,
  output logic [N*LW-1:0] mult_in_weight,
  output logic            busy,
  output logic            done,
  output logic [31:0]     perf_stall_cyc
);

  localparam int unsigned NW = LOG_N_LANES + 1;
  localparam int unsigned CW = ((OPS_W > AW) ? OPS_W : AW) + 1;

  state_e            state_q, state_d;
  logic [OPS_W-1:0]  rem_q, rem_d;
  logic [AW-1:0]     d_off_q, d_off_d;
  logic [AW-1:0]     w_off_q, w_off_d;
  logic [AW-1:0]     w_sum_c;

  logic [N-1:0]      eff_stall_c;
  logic [CW-1:0]     free_c, win_c, lim_c;
  logic [NW-1:0]     n_iss_c;
  logic              blocked_c, issue_c;

  logic              ret_valid_q, ret_valid_d;
  logic [N-1:0]      ret_stall_q, ret_stall_d;
  logic [N-1:0]      ret_fbsel_q, ret_fbsel_d;
  logic [N*BW-1:0]   ret_fbdata_q, ret_fbdata_d;
  logic [NW-1:0]     ret_niss_q, ret_niss_d;

  logic [N*LW-1:0]   cmp_data_c, cmp_wgt_c;

  logic              out_valid_q, out_valid_d;
  logic [N*LW-1:0]   out_data_q, out_data_d;
  logic [N*LW-1:0]   out_wgt_q, out_wgt_d;
  logic              skid_valid_q, skid_valid_d;
  logic [N*LW-1:0]   skid_data_q, skid_data_d;
  logic [N*LW-1:0]   skid_wgt_q, skid_wgt_d;

  // Beat size: free lanes, capped by remaining ops and by the weight window edge.
  always_comb begin : issue_calc
    eff_stall_c = stall_word | feedback_sel;
    free_c      = CW'(N) - CW'(popcount(MAX_LANES'(eff_stall_c)));
    win_c       = (wgt_period != '0) ? (CW'(wgt_period) - CW'(w_off_q)) : free_c;
    lim_c       = (CW'(rem_q) < free_c) ? CW'(rem_q) : free_c;
    if (win_c < lim_c) begin
      lim_c = win_c;
    end
    n_iss_c   = NW'(lim_c);
    blocked_c = out_valid_q && !out_ready;
    issue_c   = (state_q == ST_RUN) && !skid_valid_q && !blocked_c && (lim_c != '0);
  end

  always_comb begin : fsm_next
    state_d = state_q;
    rem_d   = rem_q;
    d_off_d = d_off_q;
    w_off_d = w_off_q;
    w_sum_c = w_off_q + AW'(n_iss_c);
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        rem_d   = init_n_ops;
        d_off_d = '0;
        w_off_d = '0;
        state_d = (init_n_ops == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        if (issue_c) begin
          rem_d   = rem_q - OPS_W'(n_iss_c);
          d_off_d = d_off_q + AW'(n_iss_c);
          w_off_d = ((wgt_period != '0) && (w_sum_c == wgt_period)) ? '0 : w_sum_c;
        end
        if (rem_d == '0) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!ret_valid_q && !skid_valid_q && (!out_valid_q || out_ready)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  lane_compactor #(
    .N  (N),
    .BW (BW),
    .LW (LW),
    .NW (NW)
  ) u_compactor (
    .eff_stall_i (ret_stall_q),
    .fb_sel_i    (ret_fbsel_q),
    .n_iss_i     (ret_niss_q),
    .rom_data_i  (rom_data_in),
    .rom_wgt_i   (rom_wgt_in),
    .fb_data_i   (ret_fbdata_q),
    .data_o      (cmp_data_c),
    .wgt_o       (cmp_wgt_c)
  );

  // Return-stage capture, then output register with skid buffer draining first.
  always_comb begin : out_path
    ret_valid_d  = issue_c;
    ret_stall_d  = issue_c ? eff_stall_c   : ret_stall_q;
    ret_fbsel_d  = issue_c ? feedback_sel  : ret_fbsel_q;
    ret_fbdata_d = issue_c ? feedback_data : ret_fbdata_q;
    ret_niss_d   = issue_c ? n_iss_c       : ret_niss_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_wgt_d    = out_wgt_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_wgt_d   = skid_wgt_q;
    if (!blocked_c) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        out_wgt_d    = skid_wgt_q;
        skid_valid_d = ret_valid_q;
        skid_data_d  = cmp_data_c;
        skid_wgt_d   = cmp_wgt_c;
      end else if (ret_valid_q) begin
        out_valid_d = 1'b1;
        out_data_d  = cmp_data_c;
        out_wgt_d   = cmp_wgt_c;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (ret_valid_q) begin
      skid_valid_d = 1'b1;
      skid_data_d  = cmp_data_c;
      skid_wgt_d   = cmp_wgt_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q        <= '0;
      d_off_q      <= '0;
      w_off_q      <= '0;
      ret_valid_q  <= 1'b0;
      ret_stall_q  <= '0;
      ret_fbsel_q  <= '0;
      ret_fbdata_q <= '0;
      ret_niss_q   <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_wgt_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_wgt_q   <= '0;
    end else begin
      rem_q        <= rem_d;
      d_off_q      <= d_off_d;
      w_off_q      <= w_off_d;
      ret_valid_q  <= ret_valid_d;
      ret_stall_q  <= ret_stall_d;
      ret_fbsel_q  <= ret_fbsel_d;
      ret_fbdata_q <= ret_fbdata_d;
      ret_niss_q   <= ret_niss_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_wgt_q    <= out_wgt_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_wgt_q   <= skid_wgt_d;
    end
  end

  // ROM read is issued in the same cycle as the decision so data returns next cycle.
  assign rom_rd         = issue_c;
  assign rom_data_addr  = init_data_base + d_off_q;
  assign rom_wgt_addr   = init_wgt_base + w_off_q;
  assign out_valid      = out_valid_q;
  assign mult_in_data   = out_data_q;
  assign mult_in_weight = out_wgt_q;
  assign busy           = (state_q != ST_IDLE);
  assign done           = (state_q == ST_DONE);

`ifdef DISPATCHER_PERF_CNT_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin : perf_next
    perf_d = perf_q;
    if (state_q == ST_LOAD) begin
      perf_d = '0;
    end else if ((state_q == ST_RUN) && !issue_c && (perf_q != '1)) begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_stall_cyc = perf_q;
`else
  assign perf_stall_cyc = '0;
`endif

endmodule

// File: tb/tb_lane_dispatcher.sv
// Directed bench for lane_dispatcher (N=4, BW=8) with a layer-level reference
// model, per-cycle scoreboard and hand-computed literal expectations.
module tb_lane_dispatcher;

  localparam int N  = 4;
  localparam int BW = 8;
  localparam int LW = 9;
  localparam int AW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [31:0]     init_n_ops;
  logic [AW-1:0]   init_data_base, init_wgt_base, wgt_period;
  logic [N-1:0]    stall_word, feedback_sel;
  logic [N*BW-1:0] feedback_data;
  logic            rom_rd;
  logic [AW-1:0]   rom_data_addr, rom_wgt_addr;
  logic [N*LW-1:0] rom_data_in, rom_wgt_in;
  logic            out_valid, out_ready;
  logic [N*LW-1:0] mult_in_data, mult_in_weight;
  logic            busy, done;
  logic [31:0]     perf_stall_cyc;

  lane_dispatcher #(
    .LOG_N_LANES   (2),
    .LOG_BIT_WIDTH (3),
    .CTRL_BIT      (1),
    .LOG_ROM_SIZE  (16),
    .OPS_W         (32)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .init_n_ops     (init_n_ops),
    .init_data_base (init_data_base),
    .init_wgt_base  (init_wgt_base),
    .wgt_period     (wgt_period),
    .stall_word     (stall_word),
    .feedback_sel   (feedback_sel),
    .feedback_data  (feedback_data),
    .rom_rd         (rom_rd),
    .rom_data_addr  (rom_data_addr),
    .rom_wgt_addr   (rom_wgt_addr),
    .rom_data_in    (rom_data_in),
    .rom_wgt_in     (rom_wgt_in),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .mult_in_data   (mult_in_data),
    .mult_in_weight (mult_in_weight),
    .busy           (busy),
    .done           (done),
    .perf_stall_cyc (perf_stall_cyc)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [N*LW-1:0] exp_d_q[$], exp_w_q[$], acc_d[$], acc_w[$];
  logic [AW-1:0]   exp_ad_q[$], exp_aw_q[$], log_ad[$], log_aw[$];
  bit              chk_en = 1'b0;

  function automatic logic [LW-1:0] romw(input logic [AW-1:0] a);
    return {1'b1, a[7:0]};
  endfunction

  // ROM with one-cycle read latency
  logic [AW-1:0] ra_q, wa_q;
  always @(posedge clk) begin
    ra_q <= rom_data_addr;
    wa_q <= rom_wgt_addr;
  end
  always_comb begin
    rom_data_in = '0;
    rom_wgt_in  = '0;
    for (int i = 0; i < N; i++) begin
      rom_data_in[i*LW +: LW] = romw(ra_q + AW'(i));
      rom_wgt_in[i*LW +: LW]  = romw(wa_q + AW'(i));
    end
  end

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Unroll a whole layer into expected read addresses and beats.
  task automatic build_model(input int n_ops, input int dbase, input int wbase, input int period,
                             input logic [N-1:0] stall, input logic [N-1:0] fbsel,
                             input logic [N*BW-1:0] fbdata);
    int rem, d, w, free, n, k;
    logic [N-1:0] eff;
    logic [N*LW-1:0] bd, bwt;
    exp_d_q.delete(); exp_w_q.delete(); exp_ad_q.delete(); exp_aw_q.delete();
    eff  = stall | fbsel;
    free = N - $countones(eff);
    rem  = n_ops; d = 0; w = 0;
    while (rem > 0 && free > 0) begin
      n = free;
      if (rem < n) n = rem;
      if (period != 0 && (period - w) < n) n = period - w;
      exp_ad_q.push_back(AW'(dbase + d));
      exp_aw_q.push_back(AW'(wbase + w));
      bd = '0; bwt = '0; k = 0;
      for (int i = 0; i < N; i++) begin
        if (!eff[i]) begin
          if (k < n) begin
            bd[i*LW +: LW]  = romw(AW'(dbase + d + k));
            bwt[i*LW +: LW] = romw(AW'(wbase + w + k));
          end
          k++;
        end else if (fbsel[i]) begin
          bd[i*LW +: LW] = {1'b1, fbdata[i*BW +: BW]};
        end
      end
      exp_d_q.push_back(bd);
      exp_w_q.push_back(bwt);
      rem -= n; d += n; w += n;
      if (w == period) w = 0;
    end
  endtask

  // Per-cycle scoreboard
  bit              prev_hold = 1'b0;
  logic [N*LW-1:0] prev_d, prev_w;
  always @(negedge clk) begin
    if (rst || !chk_en) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_data", 64'(mult_in_data), 64'(prev_d));
        check("hold_weight", 64'(mult_in_weight), 64'(prev_w));
      end
      if (out_valid && !out_ready) check("no_issue_when_blocked", 64'(rom_rd), 64'd0);
      if (rom_rd) begin
        log_ad.push_back(rom_data_addr);
        log_aw.push_back(rom_wgt_addr);
        if (exp_ad_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_rom_rd: got addr %h expected no read", rom_data_addr);
        end else begin
          check("rom_data_addr", 64'(rom_data_addr), 64'(exp_ad_q.pop_front()));
          check("rom_wgt_addr", 64'(rom_wgt_addr), 64'(exp_aw_q.pop_front()));
        end
      end
      if (out_valid && out_ready) begin
        acc_d.push_back(mult_in_data);
        acc_w.push_back(mult_in_weight);
        if (exp_d_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_beat: got %h expected no beat", mult_in_data);
        end else begin
          check("beat_data", 64'(mult_in_data), 64'(exp_d_q.pop_front()));
          check("beat_weight", 64'(mult_in_weight), 64'(exp_w_q.pop_front()));
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_d    = mult_in_data;
      prev_w    = mult_in_weight;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_inputs(input int n_ops, input int dbase, input int wbase, input int period,
                            input logic [N-1:0] stall, input logic [N-1:0] fbsel,
                            input logic [N*BW-1:0] fbdata);
    init_n_ops     = 32'(n_ops);
    init_data_base = AW'(dbase);
    init_wgt_base  = AW'(wbase);
    wgt_period     = AW'(period);
    stall_word     = stall;
    feedback_sel   = fbsel;
    feedback_data  = fbdata;
  endtask

  // Cycle k = k-th cycle after the start cycle's edge (LOAD is cycle 0).
  task automatic run_layer(input int n_ops, input int dbase, input int wbase, input int period,
                           input logic [N-1:0] stall, input logic [N-1:0] fbsel,
                           input logic [N*BW-1:0] fbdata, input int hold_at, input int hold_len,
                           output int first_ov, output int done_at);
    set_inputs(n_ops, dbase, wbase, period, stall, fbsel, fbdata);
    build_model(n_ops, dbase, wbase, period, stall, fbsel, fbdata);
    acc_d.delete(); acc_w.delete(); log_ad.delete(); log_aw.delete();
    out_ready = 1'b1;
    chk_en    = 1'b1;
    start     = 1'b1;
    tick();
    start    = 1'b0;
    first_ov = -1;
    done_at  = -1;
    for (int k = 0; k < 400 && done_at < 0; k++) begin
      if (out_valid && first_ov < 0) first_ov = k;
      if (done) begin
        done_at = k;
      end else begin
        out_ready = !(k >= hold_at && k < hold_at + hold_len);
        tick();
      end
    end
    if (done_at < 0) begin
      n_vec++; n_err++;
      $display("FAIL done_timeout: got no done expected done within 400 cycles");
    end
    out_ready = 1'b1;
    tick();
    check("done_one_cycle", 64'(done), 64'd0);
    check("idle_after_done", 64'(busy), 64'd0);
    check("beats_left", 64'(exp_d_q.size()), 64'd0);
    check("reads_left", 64'(exp_ad_q.size()), 64'd0);
  endtask

  initial begin
    int fo, da;
    rst = 1'b1;
    start = 1'b0;
    out_ready = 1'b1;
    set_inputs(0, 0, 0, 0, '0, '0, '0);
    repeat (3) tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_data", 64'(mult_in_data), 64'd0);
    check("rst_perf", 64'(perf_stall_cyc), 64'd0);
    rst = 1'b0;
    tick();

    // 1: plain layer
    run_layer(8, 'h10, 'h40, 0, 4'b0000, 4'b0000, 32'h0, 1000, 0, fo, da);
    check("t1_first_valid", 64'(fo), 64'd3);
    check("t1_done_cycle", 64'(da), 64'd5);
    check("t1_beats", 64'(acc_d.size()), 64'd2);
    check("t1_beat0_data", 64'(acc_d[0]), 64'({9'h113, 9'h112, 9'h111, 9'h110}));
    check("t1_beat0_wgt", 64'(acc_w[0]), 64'({9'h143, 9'h142, 9'h141, 9'h140}));
    check("t1_addr1", 64'(log_ad[1]), 64'h14);
    check("t1_perf", 64'(perf_stall_cyc), 64'd0);

    // 2: stalled lanes
    run_layer(4, 'h10, 'h40, 0, 4'b0101, 4'b0000, 32'h0, 1000, 0, fo, da);
    check("t2_beats", 64'(acc_d.size()), 64'd2);
    check("t2_beat0_data", 64'(acc_d[0]), 64'({9'h111, 9'h000, 9'h110, 9'h000}));
    check("t2_addr1", 64'(log_ad[1]), 64'h12);

    // 3: feedback lane
    run_layer(6, 'h30, 'h50, 0, 4'b0000, 4'b0010, 32'h0000_AB00, 1000, 0, fo, da);
    check("t3_beat0_data", 64'(acc_d[0]), 64'({9'h132, 9'h131, 9'h1AB, 9'h130}));
    check("t3_beat0_wgt", 64'(acc_w[0]), 64'({9'h152, 9'h151, 9'h000, 9'h150}));
    check("t3_addr1", 64'(log_ad[1]), 64'h33);

    // 4: weight window wrap
    run_layer(12, 'h20, 'h80, 6, 4'b0000, 4'b0000, 32'h0, 1000, 0, fo, da);
    check("t4_beats", 64'(log_aw.size()), 64'd4);
    check("t4_waddr0", 64'(log_aw[0]), 64'h80);
    check("t4_waddr1", 64'(log_aw[1]), 64'h84);
    check("t4_waddr2", 64'(log_aw[2]), 64'h80);
    check("t4_waddr3", 64'(log_aw[3]), 64'h84);
    check("t4_beat1_data", 64'(acc_d[1]), 64'({9'h000, 9'h000, 9'h125, 9'h124}));

    // 5: backpressure mid-layer
    run_layer(16, 'h60, 'h70, 0, 4'b0000, 4'b0000, 32'h0, 4, 5, fo, da);
    check("t5_beats", 64'(acc_d.size()), 64'd4);
    check("t5_beat3_data", 64'(acc_d[3]), 64'({9'h16F, 9'h16E, 9'h16D, 9'h16C}));

    // 6: reset during RUN, then clean reruns
    chk_en = 1'b0;
    set_inputs(32, 0, 0, 0, '0, '0, '0);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check("t6_busy_before_rst", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check("t6_async_busy", 64'(busy), 64'd0);
    check("t6_async_valid", 64'(out_valid), 64'd0);
    tick();
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_valid", 64'(out_valid), 64'd0);
    rst = 1'b0;
    tick();
    run_layer(8, 'h10, 'h40, 0, 4'b0000, 4'b0000, 32'h0, 1000, 0, fo, da);
    check("t6_rerun_first_valid", 64'(fo), 64'd3);
    check("t6_rerun_done", 64'(da), 64'd5);
    check("t6_rerun_beat0", 64'(acc_d[0]), 64'({9'h113, 9'h112, 9'h111, 9'h110}));
    run_layer(0, 'h10, 'h40, 0, 4'b0000, 4'b0000, 32'h0, 1000, 0, fo, da);
    check("t6_zero_ops_done", 64'(da), 64'd1);
    check("t6_zero_ops_reads", 64'(log_ad.size()), 64'd0);
    check("t6_zero_ops_beats", 64'(acc_d.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
